// File: rtl/parallel_serial_if.sv
// Word-in / byte-out stream bundle for parallel_serial.
// The slave modport is the block's view. The master modport is the load source plus the byte sink.
interface parallel_serial_if #(parameter int N = 4);
    logic [8*N-1:0] data_parallel;
    logic           load_valid;
    logic           load_ready;
    logic [7:0]     data_serial;
    logic           serial_valid;
    logic           serial_ready;
    logic           serial_last;
    logic           word_done;
    logic           busy;

    modport master (
        output data_parallel, load_valid, serial_ready,
        input  load_ready, data_serial, serial_valid, serial_last, word_done, busy
    );

    modport slave (
        input  data_parallel, load_valid, serial_ready,
        output load_ready, data_serial, serial_valid, serial_last, word_done, busy
    );
endinterface

// File: rtl/parallel_serial.sv
// Serialises 8*N-bit words LSB-first onto a byte stream. Byte 0 of a word appears one cycle after the word is accepted.
// Backpressure: serial_ready low holds the byte. A pending slot lets the next word load while the current word drains.
module parallel_serial #(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst,
    parallel_serial_if.slave  bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    logic [8*N-1:0] active_q, active_d;
    logic           act_vld_q, act_vld_d;
    logic [8*N-1:0] pend_q, pend_d;
    logic           pend_vld_q, pend_vld_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           word_done_q, word_done_d;

    logic is_last, xfer, last_xfer, accept;

    assign is_last   = act_vld_q && (cnt_q == LAST_IDX);
    assign xfer      = act_vld_q && bus.serial_ready;
    assign last_xfer = xfer && is_last;
    assign accept    = bus.load_valid && !pend_vld_q;

    assign bus.load_ready   = !pend_vld_q;
    assign bus.serial_valid = act_vld_q;
    assign bus.data_serial  = active_q[7:0];
    assign bus.serial_last  = is_last;
    assign bus.word_done    = word_done_q;
    assign bus.busy         = act_vld_q || pend_vld_q;

    always_comb begin
        active_d    = active_q;
        act_vld_d   = act_vld_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        cnt_d       = cnt_q;
        word_done_d = last_xfer;

        if (last_xfer) begin
            cnt_d = '0;
            // A held pending word takes precedence; load_ready is low then, so no acceptance can collide.
            if (pend_vld_q) begin
                active_d   = pend_q;
                pend_vld_d = 1'b0;
            end else if (accept) begin
                active_d = bus.data_parallel;
            end else begin
                active_d  = '0;
                act_vld_d = 1'b0;
            end
        end else begin
            if (xfer) begin
                active_d = active_q >> 8;
                cnt_d    = cnt_q + CW'(1);
            end
            if (accept) begin
                if (!act_vld_q) begin
                    active_d  = bus.data_parallel;
                    act_vld_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    pend_d     = bus.data_parallel;
                    pend_vld_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q    <= '0;
            act_vld_q   <= 1'b0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            cnt_q       <= '0;
            word_done_q <= 1'b0;
        end else begin
            active_q    <= active_d;
            act_vld_q   <= act_vld_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            cnt_q       <= cnt_d;
            word_done_q <= word_done_d;
        end
    end
endmodule

// File: tb/tb_parallel_serial.sv
// Directed bench for parallel_serial: an N=4 instance and an N=1 instance share clock and reset.
module tb_parallel_serial;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    parallel_serial_if #(.N(4)) bus4 ();
    parallel_serial_if #(.N(1)) bus1 ();

    parallel_serial #(.N(4)) u_ps4 (.clk(clk), .rst(rst), .bus(bus4));
    parallel_serial #(.N(1)) u_ps1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset4(input string tag);
        check({tag, ".data"},  64'(bus4.data_serial),  64'h0);
        check({tag, ".valid"}, 64'(bus4.serial_valid), 64'h0);
        check({tag, ".last"},  64'(bus4.serial_last),  64'h0);
        check({tag, ".wdone"}, 64'(bus4.word_done),    64'h0);
        check({tag, ".busy"},  64'(bus4.busy),         64'h0);
        check({tag, ".lrdy"},  64'(bus4.load_ready),   64'h1);
    endtask

    task automatic check_byte(input string tag, input logic [7:0] b, input logic last);
        check({tag, ".valid"}, 64'(bus4.serial_valid), 64'h1);
        check({tag, ".data"},  64'(bus4.data_serial),  64'(b));
        check({tag, ".last"},  64'(bus4.serial_last),  64'(last));
    endtask

    initial begin
        logic [63:0] seq;
        int          wd_cnt;

        bus4.data_parallel = '0; bus4.load_valid = 1'b0; bus4.serial_ready = 1'b0;
        bus1.data_parallel = '0; bus1.load_valid = 1'b0; bus1.serial_ready = 1'b0;

        #1 rst = 1'b1;
        #1;
        check_reset4("rst");
        check("rst.n1_busy", 64'(bus1.busy), 64'h0);
        check("rst.n1_lrdy", 64'(bus1.load_ready), 64'h1);
        step();
        rst = 1'b0;

        // Single word, sink always ready
        seq = 64'h44332211;
        bus4.data_parallel = 32'h44332211; bus4.load_valid = 1'b1; bus4.serial_ready = 1'b1;
        step();
        bus4.load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_byte($sformatf("single.b%0d", i), seq[8*i +: 8], i == 3);
            step();
        end
        check("single.wdone", 64'(bus4.word_done), 64'h1);
        check("single.busy",  64'(bus4.busy),      64'h0);
        check("single.valid", 64'(bus4.serial_valid), 64'h0);
        step();
        check("single.wdone_off", 64'(bus4.word_done), 64'h0);

        // Backpressure on byte 1
        bus4.load_valid = 1'b1;
        step();
        bus4.load_valid = 1'b0;
        check_byte("bp.b0", 8'h11, 1'b0);
        step();
        bus4.serial_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_byte($sformatf("bp.hold%0d", i), 8'h22, 1'b0);
            step();
        end
        bus4.serial_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            check_byte($sformatf("bp.b%0d", i), seq[8*i +: 8], i == 3);
            step();
        end
        check("bp.wdone", 64'(bus4.word_done), 64'h1);
        check("bp.busy",  64'(bus4.busy),      64'h0);
        step();

        // Back-to-back words, no bubble between them
        seq = 64'h8877665544332211;
        wd_cnt = 0;
        bus4.data_parallel = 32'h44332211; bus4.load_valid = 1'b1;
        step();
        bus4.data_parallel = 32'h88776655;
        for (int i = 0; i < 8; i++) begin
            check_byte($sformatf("b2b.b%0d", i), seq[8*i +: 8], (i == 3) || (i == 7));
            if (bus4.word_done) wd_cnt++;
            step();
            bus4.load_valid = 1'b0;
        end
        if (bus4.word_done) wd_cnt++;
        check("b2b.busy", 64'(bus4.busy), 64'h0);
        step();
        if (bus4.word_done) wd_cnt++;
        check("b2b.wdone_cnt", 64'(wd_cnt), 64'd2);

        // Full: two words accepted with the sink stalled, third refused
        bus4.serial_ready = 1'b0;
        bus4.data_parallel = 32'h44332211; bus4.load_valid = 1'b1;
        step();
        check("full.lrdy1", 64'(bus4.load_ready), 64'h1);
        bus4.data_parallel = 32'h88776655;
        step();
        check("full.lrdy2", 64'(bus4.load_ready), 64'h0);
        bus4.data_parallel = 32'hCCBBAA99;
        step();
        check("full.lrdy3", 64'(bus4.load_ready), 64'h0);
        check("full.hold",  64'(bus4.data_serial), 64'h11);
        bus4.load_valid = 1'b0;
        bus4.serial_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_byte($sformatf("full.w1b%0d", i), seq[8*i +: 8], i == 3);
            check($sformatf("full.lrdy_b%0d", i), 64'(bus4.load_ready), 64'h0);
            step();
        end
        check("full.lrdy_back", 64'(bus4.load_ready), 64'h1);
        check("full.wdone1",    64'(bus4.word_done),  64'h1);
        for (int i = 4; i < 8; i++) begin
            check_byte($sformatf("full.w2b%0d", i - 4), seq[8*i +: 8], i == 7);
            step();
        end
        check("full.wdone2", 64'(bus4.word_done), 64'h1);
        check("full.busy",   64'(bus4.busy),      64'h0);
        step();

        // Reset while byte 2 is presented and a second word is pending
        bus4.data_parallel = 32'h44332211; bus4.load_valid = 1'b1;
        step();
        bus4.data_parallel = 32'h88776655;
        step();
        bus4.load_valid = 1'b0;
        step();
        check_byte("mid.pre", 8'h33, 1'b0);
        check("mid.pre_busy", 64'(bus4.busy), 64'h1);
        check("mid.pre_lrdy", 64'(bus4.load_ready), 64'h0);
        rst = 1'b1;
        #1;
        check_reset4("mid.rst");
        step();
        rst = 1'b0;
        step();
        step();
        check("mid.post_valid", 64'(bus4.serial_valid), 64'h0);
        check("mid.post_busy",  64'(bus4.busy),         64'h0);

        // N=1: every byte is the last one
        bus1.serial_ready = 1'b1;
        bus1.data_parallel = 8'hA5; bus1.load_valid = 1'b1;
        step();
        bus1.data_parallel = 8'h5A;
        check("n1.b0.valid", 64'(bus1.serial_valid), 64'h1);
        check("n1.b0.data",  64'(bus1.data_serial),  64'hA5);
        check("n1.b0.last",  64'(bus1.serial_last),  64'h1);
        step();
        bus1.load_valid = 1'b0;
        check("n1.b1.data",  64'(bus1.data_serial),  64'h5A);
        check("n1.b1.last",  64'(bus1.serial_last),  64'h1);
        check("n1.b1.wdone", 64'(bus1.word_done),    64'h1);
        step();
        check("n1.wdone2", 64'(bus1.word_done),    64'h1);
        check("n1.valid",  64'(bus1.serial_valid), 64'h0);
        check("n1.busy",   64'(bus1.busy),         64'h0);
        step();
        check("n1.wdone_off", 64'(bus1.word_done), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/parallel_serial.md
# parallel_serial

Transmit-side counterpart of the byte collector. Accepts an 8*N-bit word over a valid/ready handshake and emits it one byte per transfer on a byte stream, least-significant byte first. Each byte is qualified by valid/ready and the final byte of each word is flagged. A one-word pending buffer lets a new word be accepted while the current word drains, so back-to-back words stream without bubbles.

## Interface
- N, default 4, bytes per word (N >= 1)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- data_parallel  input  8*N  word to send; byte k = bits [8k+7:8k]
- load_valid  input  1  data_parallel is valid
- load_ready  output  1  block can accept a word this cycle
- data_serial  output  8  current byte
- serial_valid  output  1  data_serial is valid
- serial_ready  input  1  sink accepts data_serial this cycle
- serial_last  output  1  current byte is byte N-1 of its word
- word_done  output  1  one-cycle pulse after the last byte of a word transfers
- busy  output  1  active or pending word present

## Operation
- Storage: active shift register (8*N bits) + active_valid; pending register (8*N bits) + pend_valid; byte counter of width max(1, $clog2(N)).
- Load handshake: a word is accepted when load_valid && load_ready. load_ready = !pend_valid (combinational from state only, not from load_valid or serial_ready).
- Byte handshake: a byte transfers when serial_valid && serial_ready. serial_valid = active_valid. data_serial = active[7:0]. serial_last = active_valid && (counter == N-1).
- On byte transfer that is not the last: shift active right by 8 bits, counter += 1.
- On last-byte transfer: counter <= 0; active is reloaded from the next source, chosen in priority order: pending (if pend_valid, then pend_valid <= 0), else the word accepted this cycle, else active_valid <= 0.
- On word acceptance:
  - If !active_valid, or a last-byte transfer occurs this same cycle with !pend_valid, the word goes directly to active.
  - Otherwise it goes to pending (pend_valid <= 1).
- Simultaneous last-byte transfer, pend_valid = 1 and load attempt: load_ready is 0, so no acceptance. Pending moves to active.
- Backpressure: while serial_valid && !serial_ready, data_serial, serial_last and the counter hold stable.
- word_done: registered. It is 1 in the cycle after each last-byte transfer, else 0.
- busy = active_valid || pend_valid.
- N = 1: every byte is last. The counter stays 0.
- Data words are never dropped or reordered. Bytes within a word are emitted in order 0..N-1.

## Timing
- Reset values (asserted asynchronously): data_serial = 0, serial_valid = 0, serial_last = 0, word_done = 0, busy = 0, load_ready = 1. Counter, active and pending registers are cleared.
- Reset mid-word discards both active and pending words. The first byte after reset release comes only from a new load.
- Load-to-first-byte latency from idle: word accepted at edge k gives serial_valid = 1 with byte 0 in the cycle after edge k.
- Throughput: with serial_ready held at 1, N bytes are sent per N cycles, and consecutive words follow with zero idle cycles.
- Acceptance capacity: at most two words in flight (active + pending).
- word_done asserts exactly one cycle after the edge at which the last byte transferred.

## Test plan
- Single word, N=4, load 0x44332211 with serial_ready=1: bytes 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles. serial_last is 1 only with 0x44. word_done pulses once, one cycle later. busy then drops to 0.
- Backpressure: same word, serial_ready low for 3 cycles while 0x22 is presented. data_serial holds 0x22 and the counter holds. The sequence then completes with no byte lost or duplicated.
- Back-to-back: load 0x44332211, then 0x88776655 on the next cycle, with serial_ready=1. Output is 11,22,33,44,55,66,77,88 with no gap. serial_last is set on 0x44 and 0x88. There are 2 word_done pulses.
- Full: hold serial_ready=0 and present 3 words. The first two are accepted and load_ready goes to 0 for the third. load_ready returns to 1 in the cycle after the last byte of word 1 transfers.
- Reset mid-word: assert rst while 0x33 is presented with a pending word held. All outputs go to their reset values immediately. After release there is no serial_valid until a new load.
- N=1: load 0xA5, then 0x5A. Output is 0xA5 then 0x5A, each with serial_last=1 and one word_done pulse.
